modo2_gravacao_controle: RTL and testbench
==========================================

# modo2_gravacao_controle

Recording-mode controller for the FPGAudio piano: it captures the notes the player presses and writes them to the song memory as note-code/duration words. The mode-1 playback/lesson path reads these words back. It watches the keyboard interface (`nota_feita`, `nota_codigo`) and a duration time-base pulse. It drives the memory write port directly and terminates every recording with an end-of-song marker word.

## Interface
- `ADDR_W`, 4: memory address width; `2**ADDR_W` words, with the last word always reserved for the terminator.
- `NOTE_W`, 4: note-code width; code all-ones (`FIM_CODE`) is reserved as the end-of-song marker.
- `DUR_W`, 6: duration field width, counted in `tick` periods and saturating at `2**DUR_W-1`.
- `clock`  input  1  system clock; single clock domain.
- `reset`  input  1  asynchronous, active-low reset (0 = reset).
- `iniciar`  input  1  start a new recording; sampled in `inicial` and `concluido`.
- `finalizar`  input  1  stop recording; sampled only in `espera_nota`.
- `nota_feita`  input  1  level signal, high while a key is held.
- `nota_codigo`  input  NOTE_W  code of the held key; valid while `nota_feita` is high.
- `tick`  input  1  one-cycle duration time-base pulse (1/16 beat).
- `mem_endereco`  output  ADDR_W  write address; this is the current address register.
- `mem_dado`  output  NOTE_W+DUR_W  write data `{nota, duracao}`.
- `gravaM`  output  1  memory write enable; a one-cycle pulse.
- `num_notas`  output  ADDR_W  number of notes recorded so far; equals `mem_endereco`.
- `gravando`  output  1  high in every state except `inicial` and `concluido`.
- `toca`  output  1  high in `toca_nota`; drives the sound generator.
- `cheio`  output  1  high in `concluido` when the recording ended because memory was full.
- `pronto`  output  1  high in `concluido`.
- `db_estado`  output  4  current state code.

## Operation
- All control outputs are Moore outputs decoded from the registered state.
- Datapath registers: address `end_r` (ADDR_W), note `nota_r` (NOTE_W), duration `dur_r` (DUR_W), and the `cheio_r` flag.
- States and transitions:
  - `inicial` (0): if `iniciar`, go to `inicializa`.
  - `inicializa` (1): clear `end_r` and `cheio_r`; go to `espera_nota`.
  - `espera_nota` (2):
    - If `finalizar`, go to `grava_fim`.
    - Else if `nota_feita` and `nota_codigo != FIM_CODE`, go to `registra`.
    - Otherwise stay; a key with `FIM_CODE` is ignored.
  - `registra` (3): `nota_r <= nota_codigo`, `dur_r <= 1`; go to `toca_nota`.
  - `toca_nota` (4):
    - On each `tick`, `dur_r` increments, saturating at its maximum.
    - If `nota_feita` is low, go to `grava`.
    - `finalizar` is ignored in this state.
  - `grava` (5): `gravaM=1`, `mem_dado={nota_r,dur_r}`, `mem_endereco=end_r`; go to `proximo`.
  - `proximo` (6): `end_r++`.
    - If the new value is `2**ADDR_W-1`, set `cheio_r` and go to `grava_fim`.
    - Else go to `espera_nota`.
  - `grava_fim` (7): `gravaM=1`, `mem_dado={FIM_CODE, 0}`, `mem_endereco=end_r`; go to `concluido`.
  - `concluido` (8): `pronto=1`, `cheio=cheio_r`; if `iniciar`, go to `inicializa`.
  - Unused codes go to `inicial`.
- `finalizar` and `nota_feita` together in `espera_nota`: `finalizar` wins.
- `tick` in the same cycle as the `registra` → `toca_nota` transition is not counted; counting starts in `toca_nota`.
- Duration arithmetic is unsigned DUR_W-bit with saturation and never wraps. Stored duration is at least 1.
- Address arithmetic never wraps because of the full check in `proximo`.

## Timing
- While reset is low: state = `inicial`, `end_r`, `nota_r`, `dur_r` and `cheio_r` = 0, and every output is 0. Memory contents are untouched.
- Reset asserted mid-operation (including during `grava`) returns to `inicial` immediately; no write is completed.
- Key press to `toca` high: `nota_feita` is sampled high in `espera_nota` at edge n; `registra` occupies cycle n+1; `toca` is high from cycle n+2.
- Key release to write: `nota_feita` is sampled low at edge m; `gravaM` is high exactly in cycle m+1.
- After a write, the next note press is accepted from cycle m+3.
- `finalizar` to terminator: sampled at edge k; `gravaM` for the terminator word is high in cycle k+1; `pronto` from cycle k+2.
- Full memory: the last note is written at address `2**ADDR_W-2`; the terminator is written at `2**ADDR_W-1` two cycles later; then `cheio=1` and `pronto=1`.

## Structure
- Shared package `fpgaudio_pkg`:
  - `FIM_CODE` and the word layout (`NOTE_W`, `DUR_W`), shared with the mode-1 reader's `fim_musica` detection.
  - The mode-2 state-code constants.
- One sub-module: `contador_duracao_sat`, a DUR_W saturating counter with load-to-1 and a `tick`-qualified enable.
- The rest is one FSM plus the address and note registers.

## Test plan
- Reset low mid-`toca_nota` with `end_r=3` → all outputs 0, `db_estado=0`, no `gravaM`; after release, `iniciar` starts a recording at address 0.
- `iniciar`; press code 5 for 10 ticks; release → one `gravaM` pulse with address 0, data `{5,11}`; `num_notas=1`.
- Press code 2 and hold for 100 ticks (`DUR_W=6`) → written data `{2,63}` (saturated).
- `finalizar` and `nota_feita` (code 3) asserted together in `espera_nota` with `end_r=1` → single write `{15,0}` at address 1; `pronto=1`, `cheio=0`; no note recorded.
- Record 15 short notes without `finalizar` → notes at addresses 0..14, terminator at 15, `cheio=1`, `pronto=1`; a further key press produces no write.
- Key with code 15 held in `espera_nota` → state stays 2, no write, `toca=0`.

Source files
------------

// File: rtl/modo2_gravacao_controle_pkg.sv
// fpgaudio_pkg: song-memory word layout, end-of-song marker and the
// mode-2 (recording) state codes. The mode-1 reader uses the same package
// for its fim_musica detection.
package fpgaudio_pkg;

    localparam int NOTE_W = 4;
    localparam int DUR_W  = 6;
    localparam int WORD_W = NOTE_W + DUR_W;

    // An all-ones note code marks the end of a song.
    localparam logic [NOTE_W-1:0] FIM_CODE = {NOTE_W{1'b1}};
    localparam logic [DUR_W-1:0]  DUR_MAX  = {DUR_W{1'b1}};

    typedef enum logic [3:0] {
        ST_INICIAL     = 4'd0,
        ST_INICIALIZA  = 4'd1,
        ST_ESPERA_NOTA = 4'd2,
        ST_REGISTRA    = 4'd3,
        ST_TOCA_NOTA   = 4'd4,
        ST_GRAVA       = 4'd5,
        ST_PROXIMO     = 4'd6,
        ST_GRAVA_FIM   = 4'd7,
        ST_CONCLUIDO   = 4'd8
    } estado_t;

    // Song-memory word: note code in the upper bits, duration below it.
    function automatic logic [WORD_W-1:0] monta_palavra(input logic [NOTE_W-1:0] nota,
                                                       input logic [DUR_W-1:0]  dur);
        return {nota, dur};
    endfunction

endpackage

// File: rtl/modo2_gravacao_controle_if.sv
// Keyboard + song-memory write port bundle for the recording controller.
// master = controller side, slave = keyboard/memory side.
interface modo2_gravacao_controle_if #(
    parameter int ADDR_W = 4
);
    logic                                              nota_feita;
    logic [fpgaudio_pkg::NOTE_W-1:0]                   nota_codigo;
    logic                                              tick;
    logic [ADDR_W-1:0]                                 mem_endereco;
    logic [fpgaudio_pkg::NOTE_W+fpgaudio_pkg::DUR_W-1:0] mem_dado;
    logic                                              gravaM;

    modport master (
        input  nota_feita, nota_codigo, tick,
        output mem_endereco, mem_dado, gravaM
    );

    modport slave (
        output nota_feita, nota_codigo, tick,
        input  mem_endereco, mem_dado, gravaM
    );
endinterface

// File: rtl/modo2_gravacao_controle_contador.sv
// contador_duracao_sat: note-duration counter in tick periods. Loads 1 when a
// note is registered and then counts ticks while enabled, sticking at max.
module contador_duracao_sat
    import fpgaudio_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             carrega,
    input  logic             conta,
    input  logic             tick,
    output logic [DUR_W-1:0] duracao
);

    logic [DUR_W-1:0] r_dur;

    function automatic logic [DUR_W-1:0] inc_sat(input logic [DUR_W-1:0] v);
        return (v == DUR_MAX) ? v : v + DUR_W'(1);
    endfunction

    // Load has priority; counting only happens on an enabled tick.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dur <= '0;
        end else if (carrega) begin
            r_dur <= DUR_W'(1);
        end else if (conta && tick) begin
            r_dur <= inc_sat(r_dur);
        end
    end

    assign duracao = r_dur;

endmodule

// File: rtl/modo2_gravacao_controle.sv
// modo2_gravacao_controle: recording-mode controller. Captures held keys as
// {note, duration} words into the song memory and closes every recording with
// an end-of-song word; the last memory word is always kept for that marker.
module modo2_gravacao_controle
    import fpgaudio_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     iniciar,
    input  logic                     finalizar,
    modo2_gravacao_controle_if.master bus,
    output logic [ADDR_W-1:0]        num_notas,
    output logic                     gravando,
    output logic                     toca,
    output logic                     cheio,
    output logic                     pronto,
    output logic [3:0]               db_estado
);

    estado_t           r_estado;
    estado_t           w_prox;
    logic [ADDR_W-1:0] r_end;
    logic [NOTE_W-1:0] r_nota;
    logic              r_cheio;
    logic [ADDR_W-1:0] w_end_inc;
    logic [DUR_W-1:0]  w_dur;
    logic              w_carrega;
    logic              w_conta;

    assign w_end_inc = r_end + ADDR_W'(1);
    assign w_carrega = (r_estado == ST_REGISTRA);
    assign w_conta   = (r_estado == ST_TOCA_NOTA);

    contador_duracao_sat u_dur (
        .clock   (clock),
        .reset   (reset),
        .carrega (w_carrega),
        .conta   (w_conta),
        .tick    (bus.tick),
        .duracao (w_dur)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_estado <= ST_INICIAL;
        else        r_estado <= w_prox;
    end

    // Next-state logic; finalizar beats a simultaneous key press.
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            ST_INICIAL:     if (iniciar) w_prox = ST_INICIALIZA;
            ST_INICIALIZA:  w_prox = ST_ESPERA_NOTA;
            ST_ESPERA_NOTA: begin
                if (finalizar)
                    w_prox = ST_GRAVA_FIM;
                else if (bus.nota_feita && (bus.nota_codigo != FIM_CODE))
                    w_prox = ST_REGISTRA;
            end
            ST_REGISTRA:    w_prox = ST_TOCA_NOTA;
            ST_TOCA_NOTA:   if (!bus.nota_feita) w_prox = ST_GRAVA;
            ST_GRAVA:       w_prox = ST_PROXIMO;
            ST_PROXIMO:     w_prox = (w_end_inc == {ADDR_W{1'b1}}) ? ST_GRAVA_FIM : ST_ESPERA_NOTA;
            ST_GRAVA_FIM:   w_prox = ST_CONCLUIDO;
            ST_CONCLUIDO:   if (iniciar) w_prox = ST_INICIALIZA;
            default:        w_prox = ST_INICIAL;
        endcase
    end

    // Address, note and full-flag registers. Reaching the last word in
    // proximo means only the terminator still fits, so the flag is set there.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_end   <= '0;
            r_nota  <= '0;
            r_cheio <= 1'b0;
        end else begin
            case (r_estado)
                ST_INICIALIZA: begin
                    r_end   <= '0;
                    r_cheio <= 1'b0;
                end
                ST_REGISTRA: r_nota <= bus.nota_codigo;
                ST_PROXIMO: begin
                    r_end <= w_end_inc;
                    if (w_end_inc == {ADDR_W{1'b1}}) r_cheio <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        bus.gravaM   = 1'b0;
        bus.mem_dado = '0;
        case (r_estado)
            ST_GRAVA: begin
                bus.gravaM   = 1'b1;
                bus.mem_dado = monta_palavra(r_nota, w_dur);
            end
            ST_GRAVA_FIM: begin
                bus.gravaM   = 1'b1;
                bus.mem_dado = monta_palavra(FIM_CODE, '0);
            end
            default: ;
        endcase
    end

    assign bus.mem_endereco = r_end;
    assign num_notas        = r_end;
    assign gravando         = (r_estado != ST_INICIAL) && (r_estado != ST_CONCLUIDO);
    assign toca             = (r_estado == ST_TOCA_NOTA);
    assign pronto           = (r_estado == ST_CONCLUIDO);
    assign cheio            = (r_estado == ST_CONCLUIDO) && r_cheio;
    assign db_estado        = r_estado;

endmodule

// File: tb/tb_modo2_gravacao_controle.sv
// Bench for modo2_gravacao_controle: directed session flow with randomized
// note codes, hold lengths and tick patterns; expected words and memory image
// come from the recording rules (duration = 1 + ticks seen while sounding,
// capped at 63; terminator {15,0} after the last note).
module tb_modo2_gravacao_controle;
    import fpgaudio_pkg::*;

    localparam int ADDR_W = 4;
    localparam int NWORDS = 1 << ADDR_W;
    localparam logic [9:0] FIM_WORD = 10'h3C0;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              iniciar = 1'b0;
    logic              finalizar = 1'b0;
    logic [ADDR_W-1:0] num_notas;
    logic              gravando, toca, cheio, pronto;
    logic [3:0]        db_estado;

    modo2_gravacao_controle_if #(.ADDR_W(ADDR_W)) bus ();

    modo2_gravacao_controle #(.ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .finalizar (finalizar),
        .bus       (bus),
        .num_notas (num_notas),
        .gravando  (gravando),
        .toca      (toca),
        .cheio     (cheio),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    int         wr_cnt = 0;
    int         exp_wr = 0;
    int         n_notes = 0;
    logic [9:0] tb_mem  [NWORDS];
    logic [9:0] exp_mem [NWORDS];

    // Song memory as seen by the bench: every accepted write lands here.
    always @(posedge clock) begin
        if (reset === 1'b1 && bus.gravaM === 1'b1) begin
            tb_mem[bus.mem_endereco] <= bus.mem_dado;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] palavra(input logic [3:0] c, input int ticks);
        int d;
        d = 1 + ticks;
        if (d > 63) d = 63;
        return {c, 6'(d)};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Record one note starting from espera_nota; ends two cycles after the write.
    task automatic record_note(input logic [3:0] code, input int hold, input bit every_tick);
        int         ticks;
        int         addr;
        logic [9:0] w;
        ticks = 0;
        addr  = n_notes;
        bus.nota_feita  = 1'b1;
        bus.nota_codigo = code;
        bus.tick        = 1'b0;
        step();
        chk("registra_state", 32'(db_estado), 32'd3);
        chk("registra_toca", 32'(toca), 32'd0);
        bus.tick = every_tick ? 1'b1 : rnd_bit();   // not counted
        step();
        chk("toca_on", 32'(toca), 32'd1);
        for (int i = 0; i < hold; i++) begin
            bus.tick = every_tick ? 1'b1 : rnd_bit();
            if (bus.tick) ticks++;
            step();
        end
        bus.nota_feita = 1'b0;
        bus.tick = every_tick ? 1'b0 : rnd_bit();
        if (bus.tick) ticks++;
        step();
        w = palavra(code, ticks);
        chk("grava_we", 32'(bus.gravaM), 32'd1);
        chk("grava_addr", 32'(bus.mem_endereco), 32'(addr));
        chk("grava_data", 32'(bus.mem_dado), 32'(w));
        exp_mem[addr] = w;
        exp_wr++;
        n_notes++;
        bus.tick = 1'b0;
        step();
        chk("proximo_we", 32'(bus.gravaM), 32'd0);
        step();
        chk("num_notas", 32'(num_notas), 32'(n_notes));
        chk("after_note_state", 32'(db_estado), (n_notes == NWORDS - 1) ? 32'd7 : 32'd2);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_estado"}, 32'(db_estado), 32'd0);
        chk({tag, "_gravando"}, 32'(gravando), 32'd0);
        chk({tag, "_toca"}, 32'(toca), 32'd0);
        chk({tag, "_pronto"}, 32'(pronto), 32'd0);
        chk({tag, "_cheio"}, 32'(cheio), 32'd0);
        chk({tag, "_we"}, 32'(bus.gravaM), 32'd0);
        chk({tag, "_addr"}, 32'(bus.mem_endereco), 32'd0);
        chk({tag, "_data"}, 32'(bus.mem_dado), 32'd0);
        chk({tag, "_num"}, 32'(num_notas), 32'd0);
    endtask

    task automatic start_recording();
        iniciar = 1'b1;
        step();
        chk("inicializa_state", 32'(db_estado), 32'd1);
        iniciar = 1'b0;
        step();
        chk("espera_state", 32'(db_estado), 32'd2);
        chk("espera_addr", 32'(bus.mem_endereco), 32'd0);
        chk("espera_gravando", 32'(gravando), 32'd1);
        n_notes = 0;
    endtask

    initial begin
        bus.nota_feita  = 1'b0;
        bus.nota_codigo = '0;
        bus.tick        = 1'b0;

        // Reset state
        repeat (3) step();
        chk_all_zero("reset");
        reset = 1'b1;
        step();
        chk("idle_state", 32'(db_estado), 32'd0);

        // Session 1: one note of exactly 10 ticks, then finalizar racing a key
        start_recording();
        record_note(4'd5, 10, 1'b1);
        chk("note5_word", 32'(exp_mem[0]), 32'(10'h14B));
        bus.nota_feita  = 1'b1;
        bus.nota_codigo = 4'd3;
        finalizar       = 1'b1;
        step();
        chk("fim_state", 32'(db_estado), 32'd7);
        chk("fim_we", 32'(bus.gravaM), 32'd1);
        chk("fim_addr", 32'(bus.mem_endereco), 32'd1);
        chk("fim_data", 32'(bus.mem_dado), 32'(FIM_WORD));
        exp_mem[1] = FIM_WORD;
        exp_wr++;
        finalizar      = 1'b0;
        bus.nota_feita = 1'b0;
        step();
        chk("done_pronto", 32'(pronto), 32'd1);
        chk("done_cheio", 32'(cheio), 32'd0);
        chk("done_gravando", 32'(gravando), 32'd0);
        chk("done_num", 32'(num_notas), 32'd1);
        chk("s1_mem0", 32'(tb_mem[0]), 32'(exp_mem[0]));
        chk("s1_mem1", 32'(tb_mem[1]), 32'(exp_mem[1]));
        chk("s1_wrcnt", 32'(wr_cnt), 32'(exp_wr));

        // Session 2: saturating note, two random notes, reset while sounding
        start_recording();
        record_note(4'd2, 100, 1'b1);
        chk("sat_word", 32'(exp_mem[0]), 32'(10'h0BF));
        for (int i = 0; i < 2; i++)
            record_note(4'($urandom_range(0, 14)), $urandom_range(0, 20), 1'b0);
        bus.nota_feita  = 1'b1;
        bus.nota_codigo = 4'd7;
        step();
        step();
        chk("pre_reset_toca", 32'(toca), 32'd1);
        chk("pre_reset_addr", 32'(bus.mem_endereco), 32'd3);
        repeat (3) begin
            bus.tick = rnd_bit();
            step();
        end
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        bus.nota_feita = 1'b0;
        step();
        chk("rst_hold_we", 32'(bus.gravaM), 32'd0);
        reset = 1'b1;
        step();
        chk("post_rst_state", 32'(db_estado), 32'd0);
        chk("post_rst_wrcnt", 32'(wr_cnt), 32'(exp_wr));

        // Session 3: reserved code ignored, then fill the memory
        start_recording();
        bus.nota_feita  = 1'b1;
        bus.nota_codigo = 4'hF;
        repeat (5) begin
            step();
            chk("fimkey_state", 32'(db_estado), 32'd2);
            chk("fimkey_toca", 32'(toca), 32'd0);
        end
        chk("fimkey_wrcnt", 32'(wr_cnt), 32'(exp_wr));
        bus.nota_feita = 1'b0;
        step();
        for (int i = 0; i < NWORDS - 1; i++)
            record_note(4'($urandom_range(0, 14)), $urandom_range(0, 6), 1'b0);
        chk("full_fim_we", 32'(bus.gravaM), 32'd1);
        chk("full_fim_addr", 32'(bus.mem_endereco), 32'(NWORDS - 1));
        chk("full_fim_data", 32'(bus.mem_dado), 32'(FIM_WORD));
        exp_mem[NWORDS-1] = FIM_WORD;
        exp_wr++;
        step();
        chk("full_cheio", 32'(cheio), 32'd1);
        chk("full_pronto", 32'(pronto), 32'd1);
        bus.nota_feita  = 1'b1;
        bus.nota_codigo = 4'd4;
        repeat (6) step();
        chk("full_press_state", 32'(db_estado), 32'd8);
        chk("full_press_wrcnt", 32'(wr_cnt), 32'(exp_wr));
        bus.nota_feita = 1'b0;
        for (int a = 0; a < NWORDS; a++)
            chk($sformatf("mem_%0d", a), 32'(tb_mem[a]), 32'(exp_mem[a]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
